serial_subtractor: RTL

Bit-serial two's-complement subtractor for the Baby accumulator datapath, built around the quad XOR stage (sum = a ⊕ ¬b ⊕ carry) plus a carry flip-flop and operand/result shift registers. It computes either A − B (SUB) or 0 − B (LDN) one bit per clock, LSB first, exactly as the original machine did. The block sits between the store/accumulator word registers and the accumulator load path. It exposes a start/busy/done handshake to the control sequencer.

---
 rtl/serial_subtractor.sv | 93 +++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: RESULT = A + ~B + 1, LSB first, one bit per clock.
// LDN mode (NEGATE=1) forces the minuend to zero, producing 0 - B.
module serial_subtractor #(
    parameter int WIDTH             = 32,
    parameter int PROPAGATION_DELAY = 15
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             NEGATE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             CARRY
);

    localparam int CW = $clog2(WIDTH);

    // PROPAGATION_DELAY only shapes the behavioural model's output timing; this
    // implementation is ideal-registered, so the parameter is validated but unused.
    if (WIDTH < 2 || PROPAGATION_DELAY < 0) begin : g_bad_params
        $error("serial_subtractor: WIDTH must be >= 2 and PROPAGATION_DELAY >= 0");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic             carry;

    logic a_bit;
    logic nb_bit;
    logic sum;
    logic carry_next;
    logic last;

    // One full-adder slice: the quad XOR stage plus the majority carry.
    always_comb begin
        a_bit      = a_reg[count];
        nb_bit     = ~b_reg[count];
        sum        = a_bit ^ nb_bit ^ carry;
        carry_next = (a_bit & nb_bit) | (a_bit & carry) | (nb_bit & carry);
        last       = (count == CW'(WIDTH - 1));
    end

    // NOTE: every register below uses <= so all updates see pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            count  <= '0;
            carry  <= 1'b0;
            RESULT <= '0;
            CARRY  <= 1'b0;
        end else begin
            case (state)
                IDLE, FINISH: begin
                    if (START) begin
                        a_reg <= NEGATE ? '0 : A;
                        b_reg <= B;
                        count <= '0;
                        carry <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    acc   <= {sum, acc[WIDTH-1:1]};
                    carry <= carry_next;
                    count <= last ? '0 : count + CW'(1);
                    if (last) begin
                        RESULT <= {sum, acc[WIDTH-1:1]};
                        CARRY  <= carry_next;
                        state  <= FINISH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign BUSY = (state == SHIFT);
    assign DONE = (state == FINISH);

endmodule
